// File: rtl/irq_sched.sv
// -----------------------------------------------------------------------------
// irq_sched -- interrupt scheduler in front of the single-cycle CPU.
//
// Turns N_SRC peripheral request lines into a single INT0 request. Rising
// edges on irq_src are captured in a pending register. One enabled pending
// source is chosen, and INT0 is held until the CPU acknowledges trap entry.
// Further requests are then blocked until the handler's mret retires.
//
// Optional feature: define IRQ_ROUND_ROBIN_EN for rotating priority. The
// search then starts one past the most recently acknowledged id. When the
// macro is left undefined, selection is fixed priority with bit 0 highest.
//
// Ports:
//   clk        in   system clock, all state updates on the rising edge
//   rst        in   synchronous, active-high reset
//   irq_src    in   [N_SRC] peripheral request lines, rising edge = request
//   irq_mask   in   [N_SRC] per-source enable, 1 = enabled
//   trap_ack   in   1-cycle pulse from CPU: interrupt trap taken
//   mret       in   high in the cycle the CPU executes mret
//   INT0       out  interrupt request to the CPU (registered)
//   irq_id     out  [ID_W] index of the source being requested or serviced
//   irq_busy   out  high whenever the scheduler is not idle (registered)
//   irq_pend   out  [N_SRC] raw pending register
//   spur_mret  out  sticky: mret seen outside SERVICE, cleared only by rst
// -----------------------------------------------------------------------------
module irq_sched #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [N_SRC-1:0] irq_mask,
    input  logic             trap_ack,
    input  logic             mret,
    output logic             INT0,
    output logic [ID_W-1:0]  irq_id,
    output logic             irq_busy,
    output logic [N_SRC-1:0] irq_pend,
    output logic             spur_mret
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             int0_q;
    logic             busy_q;
    logic             spur_q, spur_d;

    logic [N_SRC-1:0] edge_w;
    logic [N_SRC-1:0] cand_w;
    logic [N_SRC-1:0] id_oh_w;
    logic [N_SRC-1:0] clr_w;
    logic [ID_W-1:0]  sel_w;
    int               start_w;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [ID_W-1:0]  last_id_q, last_id_d;
`endif

    // First set bit of vec, searching upward from index 'start' and wrapping.
    function automatic logic [ID_W-1:0] pick(input logic [N_SRC-1:0] vec,
                                             input int start);
        logic [ID_W-1:0]  sel;
        logic             found;
        logic [N_SRC-1:0] sh;
        int               idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = (start + k) % N_SRC;
            sh  = vec >> idx;
            if (!found && sh[0]) begin
                sel   = ID_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign edge_w  = irq_src & ~src_q;
    assign cand_w  = pend_q & irq_mask;
    // One-hot form of the latched id avoids indexing an N_SRC vector with ID_W bits.
    assign id_oh_w = {{(N_SRC-1){1'b0}}, 1'b1} << id_q;

`ifdef IRQ_ROUND_ROBIN_EN
    assign start_w = (int'(last_id_q) + 1) % N_SRC;
`else
    assign start_w = 0;
`endif

    assign sel_w = pick(cand_w, start_w);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        clr_w   = '0;
        // mret is only legitimate while a handler is in service; in REQ it is
        // spurious even when it coincides with trap_ack.
        spur_d  = spur_q | (mret & (state_q != ST_SERVICE));
`ifdef IRQ_ROUND_ROBIN_EN
        last_id_d = last_id_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|cand_w) begin
                    state_d = ST_REQ;
                    id_d    = sel_w;
                end
            end
            ST_REQ: begin
                if (trap_ack) begin
                    state_d = ST_SERVICE;
                    clr_w   = id_oh_w;
`ifdef IRQ_ROUND_ROBIN_EN
                    last_id_d = id_q;
`endif
                end else if (!(|(irq_mask & id_oh_w))) begin
                    // Request withdrawn by masking; the pending bit is kept.
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (mret) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A fresh edge in the clearing cycle re-pends the bit.
        pend_d = (pend_q & ~clr_w) | edge_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            // Sampling the lines during reset suppresses a false edge from a
            // source that is held high through reset.
            src_q   <= irq_src;
            pend_q  <= '0;
            id_q    <= '0;
            int0_q  <= 1'b0;
            busy_q  <= 1'b0;
            spur_q  <= 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
            last_id_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= irq_src;
            pend_q  <= pend_d;
            id_q    <= id_d;
            int0_q  <= (state_d == ST_REQ);
            busy_q  <= (state_d != ST_IDLE);
            spur_q  <= spur_d;
`ifdef IRQ_ROUND_ROBIN_EN
            last_id_q <= last_id_d;
`endif
        end
    end

    assign INT0      = int0_q;
    assign irq_id    = id_q;
    assign irq_busy  = busy_q;
    assign irq_pend  = pend_q;
    assign spur_mret = spur_q;

endmodule

// File: tb/tb_irq_sched.sv
`timescale 1ns/1ps
module tb_irq_sched;

    localparam int N  = 4;
    localparam int IW = 3;
    localparam logic [N-1:0] ALL = 4'hF;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  src;
    logic [N-1:0]  mask;
    logic          ack;
    logic          mr;
    logic          int0;
    logic [IW-1:0] id;
    logic          busy;
    logic [N-1:0]  pend;
    logic          spur;

    always #5 clk = ~clk;

    irq_sched #(.N_SRC(N), .ID_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_src   (src),
        .irq_mask  (mask),
        .trap_ack  (ack),
        .mret      (mr),
        .INT0      (int0),
        .irq_id    (id),
        .irq_busy  (busy),
        .irq_pend  (pend),
        .spur_mret (spur)
    );

    typedef struct packed {
        logic          int0;
        logic [IW-1:0] id;
        logic          busy;
        logic [N-1:0]  pend;
        logic          spur;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   started  = 1'b0;
    bit   done     = 1'b0;

    // Reference model: 0 = nothing outstanding, 1 = requesting the CPU,
    // 2 = handler running.
    int         m_mode = 0;
    int         m_id   = 0;
    int         m_last = 0;
    bit [N-1:0] m_pend = '0;
    bit [N-1:0] m_src  = '0;
    bit         m_spur = 1'b0;

    function automatic int first_hit(input bit [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (((v >> i) & 1) != 0) return i;
        end
        return 0;
    endfunction

    // Advance the model over the next clock edge using the inputs now applied,
    // and queue the outputs the DUT must show after that edge.
    task automatic model_step();
        bit [N-1:0] rise;
        bit [N-1:0] avail;
        int         start;
        exp_t       e;
        rise = src & ~m_src;
        if (rst) begin
            m_mode = 0; m_pend = '0; m_id = 0; m_last = 0; m_spur = 1'b0;
        end else begin
            if (mr && m_mode != 2) m_spur = 1'b1;
            avail = m_pend & mask;
`ifdef IRQ_ROUND_ROBIN_EN
            start = (m_last + 1) % N;
`else
            start = 0;
`endif
            if (m_mode == 0) begin
                if (avail != 0) begin
                    m_id   = first_hit(avail, start);
                    m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (ack) begin
                    m_pend = m_pend & ~(N'(1) << m_id);
                    m_last = m_id;
                    m_mode = 2;
                end else if (((mask >> m_id) & 1) == 0) begin
                    m_mode = 0;
                end
            end else if (mr) begin
                m_mode = 0;
            end
            m_pend = m_pend | rise;
        end
        m_src  = src;
        e.int0 = (m_mode == 1);
        e.id   = IW'(m_id);
        e.busy = (m_mode != 0);
        e.pend = m_pend;
        e.spur = m_spur;
        sb.push_back(e);
        started = 1'b1;
    endtask

    task automatic cyc(input logic [N-1:0] s, input logic [N-1:0] m,
                       input logic a, input logic r, input logic rs);
        @(posedge clk);
        #2;
        src = s; mask = m; ack = a; mr = r; rst = rs;
        model_step();
    endtask

    task automatic idle(input int n, input logic [N-1:0] s, input logic [N-1:0] m);
        for (int i = 0; i < n; i++) cyc(s, m, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per clock edge once the stimulus has started.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done) break;
            if (started) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("INT0",      32'(int0), 32'(e.int0));
                    chk("irq_id",    32'(id),   32'(e.id));
                    chk("irq_busy",  32'(busy), 32'(e.busy));
                    chk("irq_pend",  32'(pend), 32'(e.pend));
                    chk("spur_mret", 32'(spur), 32'(e.spur));
                end
            end
        end
    end

    initial begin
        logic [N-1:0] s;
        logic [N-1:0] m;
        logic         a;
        logic         r;
        logic         rs;

        rst = 1'b1; src = '0; mask = ALL; ack = 1'b0; mr = 1'b0;

        // Source 0 held high through reset: no request afterwards.
        cyc(4'b0001, ALL, 0, 0, 1);
        cyc(4'b0001, ALL, 0, 0, 1);
        idle(4, 4'b0001, ALL);
        idle(2, 4'b0000, ALL);

        // Single request on source 2.
        cyc(4'b0100, ALL, 0, 0, 0);
        idle(3, 4'b0000, ALL);
        cyc(4'b0000, ALL, 1, 0, 0);
        idle(4, 4'b0000, ALL);
        cyc(4'b0000, ALL, 0, 1, 0);
        idle(2, 4'b0000, ALL);

        // Sources 3 and 1 together: 1 first, then 3 one cycle after mret.
        cyc(4'b1010, ALL, 0, 0, 0);
        idle(3, 4'b0000, ALL);
        cyc(4'b0000, ALL, 1, 0, 0);
        idle(2, 4'b0000, ALL);
        cyc(4'b0000, ALL, 0, 1, 0);
        idle(3, 4'b0000, ALL);
        cyc(4'b0000, ALL, 1, 0, 0);
        idle(1, 4'b0000, ALL);
        cyc(4'b0000, ALL, 0, 1, 0);
        idle(2, 4'b0000, ALL);

        // Mask withdraw while requesting id 0, then re-enable.
        cyc(4'b0001, ALL, 0, 0, 0);
        idle(3, 4'b0001, ALL);
        cyc(4'b0001, 4'b1110, 0, 0, 0);
        idle(2, 4'b0001, 4'b1110);
        cyc(4'b0001, ALL, 0, 0, 0);
        idle(3, 4'b0000, ALL);
        cyc(4'b0000, ALL, 1, 0, 0);
        idle(1, 4'b0000, ALL);
        cyc(4'b0000, ALL, 0, 1, 0);
        idle(2, 4'b0000, ALL);

        // Re-pend race: second edge on source 2 in its trap_ack cycle.
        cyc(4'b0100, ALL, 0, 0, 0);
        idle(3, 4'b0000, ALL);
        cyc(4'b0100, ALL, 1, 0, 0);
        idle(2, 4'b0000, ALL);
        cyc(4'b0000, ALL, 0, 1, 0);
        idle(3, 4'b0000, ALL);
        cyc(4'b0000, ALL, 1, 0, 0);
        idle(1, 4'b0000, ALL);
        cyc(4'b0000, ALL, 0, 1, 0);
        idle(2, 4'b0000, ALL);

        // Spurious mret and ignored trap_ack while idle.
        cyc(4'b0000, ALL, 0, 1, 0);
        cyc(4'b0000, ALL, 1, 0, 0);
        idle(2, 4'b0000, ALL);

        // Reset while a handler is in service.
        cyc(4'b0010, ALL, 0, 0, 0);
        idle(3, 4'b0000, ALL);
        cyc(4'b1000, ALL, 1, 0, 0);
        idle(1, 4'b0000, ALL);
        cyc(4'b0000, ALL, 0, 0, 1);
        idle(3, 4'b0000, ALL);

        // Randomized traffic with a CPU that acknowledges and returns at random.
        for (int c = 0; c < 3000; c++) begin
            s = src;
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 5) == 0) s = s ^ (N'(1) << b);
            m = mask;
            if ($urandom_range(0, 29) == 0) m = m ^ (N'(1) << $urandom_range(0, N-1));
            if ($urandom_range(0, 49) == 0) m = ALL;
            a  = (m_mode == 1 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 19) == 0);
            r  = (m_mode == 2 && $urandom_range(0, 3) == 0) || ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 299) == 0);
            cyc(s, m, a, r, rs);
        end

        @(posedge clk);
        #3;
        done = 1'b1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
